alu_slice_sequencer: RTL and testbench

//  Multi-cycle controller that computes wide AND/OR/ADD/SUB by running one 4-bit ALU slice per

---
 rtl/alu_slice_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_slice_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer
//   Multi-cycle controller that evaluates wide AND/OR/ADD/SUB on one 4-bit ALU slice per clock,
//   LSB nibble first, with the carry chained between slices in a register.
//
//   Optional feature macro: ALU_SEQ_LOGIC_FASTPATH_EN
//     defined   : AND/OR finish in a single RUN cycle (all nibbles at once); ADD/SUB unchanged.
//     undefined : every op takes NUM_SLICES RUN cycles.
//
// Ports
//   clk        clock, all state on posedge
//   rst_n      synchronous active-low reset
//   start      request pulse, accepted only in IDLE or DONE
//   op         00 AND, 01 OR, 10 ADD, 11 SUB (a-b)
//   a, b       operands, latched on accepted start
//   busy       high while slices are processed
//   done       one-cycle pulse, result/flags valid from this cycle
//   result     operation result, held until next accepted start
//   carry_out  ADD carry / SUB borrow, 0 for logic ops
//   overflow   signed overflow for ADD/SUB, 0 for logic ops
//   zero       result == 0
//   slice_idx  slice currently processed, 0 outside RUN
module alu_slice_sequencer #(
  parameter int unsigned NUM_SLICES = 4,
  localparam int unsigned W = 4 * NUM_SLICES,
  localparam int unsigned IdxW = $clog2(NUM_SLICES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    result,
  output logic            carry_out,
  output logic            overflow,
  output logic            zero,
  output logic [IdxW-1:0] slice_idx
);

  localparam logic [1:0] OpAnd = 2'b00;
  localparam logic [1:0] OpOr  = 2'b01;
  localparam logic [1:0] OpAdd = 2'b10;
  localparam logic [1:0] OpSub = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   result_q, result_d;
  logic           carry_out_q, carry_out_d;
  logic           overflow_q, overflow_d;
  logic           zero_q, zero_d;

  logic           accept;
  logic           last_slice;
  logic [IdxW+1:0] bit_base;
  logic [3:0]     a_nib, b_nib, b_eff, nib;
  logic [4:0]     sum5;
  logic           c_into_msb;

  always_comb begin
    accept     = start && (state_q != StRun);
    last_slice = (idx_q == IdxW'(NUM_SLICES - 1));
    bit_base   = {idx_q, 2'b00};

    // Single slice datapath; SUB is a + ~b with carry-in seeded to 1 at accept.
    a_nib = a_q[bit_base +: 4];
    b_nib = b_q[bit_base +: 4];
    b_eff = (op_q == OpSub) ? ~b_nib : b_nib;
    sum5  = {1'b0, a_nib} + {1'b0, b_eff} + {4'b0000, carry_q};
    // Carry into bit 3 recovered from the sum bit: s3 = a3 ^ b3 ^ c3.
    c_into_msb = sum5[3] ^ a_nib[3] ^ b_eff[3];

    unique case (op_q)
      OpAnd:   nib = a_nib & b_nib;
      OpOr:    nib = a_nib | b_nib;
      default: nib = sum5[3:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;

    unique case (state_q)
      StRun: begin
`ifdef ALU_SEQ_LOGIC_FASTPATH_EN
        if (!op_q[1]) begin
          result_d    = (op_q == OpAnd) ? (a_q & b_q) : (a_q | b_q);
          carry_out_d = 1'b0;
          overflow_d  = 1'b0;
          zero_d      = (result_d == '0);
          idx_d       = '0;
          state_d     = StDone;
        end else begin
`else
        begin
`endif
          result_d[bit_base +: 4] = nib;
          carry_d = sum5[4];
          idx_d   = idx_q + IdxW'(1);
          if (last_slice) begin
            idx_d   = '0;
            state_d = StDone;
            if (op_q[1]) begin
              carry_out_d = (op_q == OpSub) ? ~sum5[4] : sum5[4];
              overflow_d  = c_into_msb ^ sum5[4];
            end else begin
              carry_out_d = 1'b0;
              overflow_d  = 1'b0;
            end
            zero_d = (result_d == '0);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Accept overrides the DONE->IDLE step to allow back-to-back operations.
    if (accept) begin
      op_d    = op;
      a_d     = a;
      b_d     = b;
      idx_d   = '0;
      carry_d = (op == OpSub);
      state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      op_q        <= OpAdd;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign slice_idx = idx_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
module tb_alu_slice_sequencer;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, carry_out, overflow, zero;
  logic [W-1:0] result;
  logic [1:0]   slice_idx;

  alu_slice_sequencer #(.NUM_SLICES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .slice_idx (slice_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [15:0]  a;
    logic [15:0]  b;
    logic [15:0]  res;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  vec_t vecs[12];
  int   nvec = 0;
  int   errs = 0;

`ifdef ALU_SEQ_LOGIC_FASTPATH_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and follow it to done, checking latency, slice_idx and outputs.
  task automatic run_vec(input vec_t v, input int k);
    int cycles;
    int exp_cyc;
    bit fast_op;
    fast_op = Fast && !v.op[1];
    exp_cyc = fast_op ? 1 : N;
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 20) begin
      chk($sformatf("v%0d slice_idx", k), 32'(slice_idx), fast_op ? 32'd0 : 32'(cycles));
      cycles++;
      tick();
    end
    chk($sformatf("v%0d latency", k), 32'(cycles), 32'(exp_cyc));
    chk($sformatf("v%0d done", k), 32'(done), 32'd1);
    chk($sformatf("v%0d result", k), 32'(result), 32'(v.res));
    chk($sformatf("v%0d carry_out", k), 32'(carry_out), 32'(v.c));
    chk($sformatf("v%0d overflow", k), 32'(overflow), 32'(v.v));
    chk($sformatf("v%0d zero", k), 32'(zero), 32'(v.z));
    tick();
    chk($sformatf("v%0d done_pulse", k), 32'(done), 32'd0);
    chk($sformatf("v%0d result_hold", k), 32'(result), 32'(v.res));
  endtask

  // Advance until done with a bound; reports a miss as a failed comparison.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({name, " done_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    int pulses;
    vecs[0]  = '{2'b10, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{2'b10, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{2'b11, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{2'b11, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{2'b00, 16'hFF00, 16'h0FF0, 16'h0F00, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'b01, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'b11, 16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{2'b00, 16'h0F0F, 16'hF0F0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{2'b10, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{2'b11, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{2'b10, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    tick(); tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    chk("rst slice_idx", 32'(slice_idx), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Start during RUN is ignored.
    op = 2'b10; a = 16'h1111; b = 16'h2222; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op = 2'b00; a = 16'h1234; b = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        pulses++;
        chk("ignore result", 32'(result), 32'h3333);
      end
      tick();
    end
    chk("ignore pulses", 32'(pulses), 32'd1);
    chk("ignore idle", 32'(busy), 32'd0);

    // Back-to-back: start in the DONE cycle.
    op = 2'b10; a = 16'h1111; b = 16'h2222; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("b2b first");
    chk("b2b first result", 32'(result), 32'h3333);
    op = 2'b01; a = 16'hF0F0; b = 16'h0F0F; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b busy", 32'(busy), 32'd1);
    chk("b2b no done", 32'(done), 32'd0);
    wait_done("b2b second");
    chk("b2b result", 32'(result), 32'hFFFF);
    tick();

    // Reset at slice 2 aborts the operation.
    op = 2'b10; a = 16'h1111; b = 16'h2222; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("abort slice_idx", 32'(slice_idx), 32'd2);
    rst_n = 1'b0;
    tick();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", 32'(result), 32'd0);
    chk("abort flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    chk("abort slice_idx0", 32'(slice_idx), 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    chk("abort no done", 32'(pulses), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
